// File: rtl/hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_stall_ctrl
//  Description : Pipeline hazard controller for the 5-stage RISC-V core.
//                Inserts load-use bubbles, issues ID-stage branch flushes
//                (deferring them across data-cache freezes), and freezes the
//                whole pipeline while the data cache services a miss.
//                Includes saturating performance counters and a sticky
//                miss-timeout error flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_stall_ctrl #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       IFID_RS1_i,
    input  logic [4:0]       IFID_RS2_i,
    input  logic             IDEX_MemRead_i,
    input  logic [4:0]       IDEX_RD_i,
    input  logic             Branch_taken_i,
    input  logic             mem_stall_i,
    output logic             PCWrite_o,
    output logic             IFID_Write_o,
    output logic             IFID_Flush_o,
    output logic             IDEX_Bubble_o,
    output logic             Pipe_Stall_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] miss_cyc_o,
    output logic [CNT_W-1:0] loaduse_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output logic             err_o
);

    // Timeout counter must be able to hold the value TIMEOUT itself.
    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_MISS   = 2'd1,
        ST_RESUME = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_pend_flush;
    logic [TO_W-1:0]   r_to_cnt;
    logic [TO_W-1:0]   w_to_inc;
    logic              r_err;
    logic [CNT_W-1:0]  r_miss_cyc;
    logic [CNT_W-1:0]  r_loaduse_cnt;
    logic [CNT_W-1:0]  r_flush_cnt;

    logic              w_lu;
    logic              w_frz;
    logic              w_in_miss;

    // Hazard detection: load in EX whose nonzero rd feeds an ID source.
    assign w_lu = IDEX_MemRead_i && (IDEX_RD_i != 5'd0) &&
                  ((IDEX_RD_i == IFID_RS1_i) || (IDEX_RD_i == IFID_RS2_i));

    // The first MISS cycle holds the freeze even if the cache already
    // dropped its stall, giving a minimum freeze of two cycles.
    assign w_in_miss = (r_state == ST_MISS);
    assign w_frz     = mem_stall_i || w_in_miss;

    // Saturating increment of the consecutive-MISS counter.
    assign w_to_inc = (r_to_cnt == TO_LIMIT) ? r_to_cnt : r_to_cnt + 1'b1;

    // Next-state logic: RESUME lasts one cycle, a new miss re-enters MISS.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN:    w_state_nxt = mem_stall_i ? ST_MISS : ST_RUN;
            ST_MISS:   w_state_nxt = mem_stall_i ? ST_MISS : ST_RESUME;
            ST_RESUME: w_state_nxt = mem_stall_i ? ST_MISS : ST_RUN;
            default:   w_state_nxt = ST_RUN;
        endcase
    end

    // Control outputs: reset forces RUN values, freeze beats load-use,
    // load-use beats flush (ID is held so the branch re-resolves later).
    always_comb begin
        PCWrite_o     = 1'b1;
        IFID_Write_o  = 1'b1;
        IFID_Flush_o  = 1'b0;
        IDEX_Bubble_o = 1'b0;
        Pipe_Stall_o  = 1'b0;
        if (rst_i) begin
            PCWrite_o    = 1'b1;
            IFID_Write_o = 1'b1;
        end else if (w_frz) begin
            PCWrite_o    = 1'b0;
            IFID_Write_o = 1'b0;
            Pipe_Stall_o = 1'b1;
        end else if (w_lu) begin
            PCWrite_o     = 1'b0;
            IFID_Write_o  = 1'b0;
            IDEX_Bubble_o = 1'b1;
        end else begin
            IFID_Flush_o = Branch_taken_i || r_pend_flush;
        end
    end

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Deferred flush: a branch taken while frozen is remembered until a
    // flush is actually issued.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_pend_flush <= 1'b0;
        end else if (w_frz && Branch_taken_i) begin
            r_pend_flush <= 1'b1;
        end else if (IFID_Flush_o) begin
            r_pend_flush <= 1'b0;
        end
    end

    // Miss timeout: count consecutive MISS cycles, latch err when the
    // count reaches the limit; err stays set until reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_to_cnt <= '0;
            r_err    <= 1'b0;
        end else if (w_in_miss) begin
            r_to_cnt <= (w_state_nxt == ST_MISS) ? w_to_inc : '0;
            if (w_to_inc == TO_LIMIT) begin
                r_err <= 1'b1;
            end
        end else begin
            r_to_cnt <= '0;
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_miss_cyc    <= '0;
            r_loaduse_cnt <= '0;
            r_flush_cnt   <= '0;
        end else begin
            if (w_in_miss && (r_miss_cyc != CNT_MAX)) begin
                r_miss_cyc <= r_miss_cyc + 1'b1;
            end
            if (IDEX_Bubble_o && (r_loaduse_cnt != CNT_MAX)) begin
                r_loaduse_cnt <= r_loaduse_cnt + 1'b1;
            end
            if (IFID_Flush_o && (r_flush_cnt != CNT_MAX)) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    assign state_o       = r_state;
    assign miss_cyc_o    = r_miss_cyc;
    assign loaduse_cnt_o = r_loaduse_cnt;
    assign flush_cnt_o   = r_flush_cnt;
    assign err_o         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_stall_ctrl
//  Description : Self-checking bench for hazard_stall_ctrl. Two instances
//                share the stimulus: one with default parameters, one with
//                narrow counters and a short timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_stall_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic [4:0] rs1, rs2, rd;
    logic memread, bt, stall;

    logic a_pc, a_ifw, a_flush, a_bub, a_stall, a_err;
    logic [1:0] a_state;
    logic [31:0] a_miss, a_lu, a_fl;
    logic b_pc, b_ifw, b_flush, b_bub, b_stall, b_err;
    logic [1:0] b_state;
    logic [3:0] b_miss, b_lu, b_fl;

    int errors = 0;
    int checks = 0;

    // Reference model state.
    int     m_st;
    bit     m_pend;
    longint m_miss, m_lu, m_fl;
    int     m_run;
    bit     m_err_a, m_err_b;
    logic   e_pc, e_ifw, e_flush, e_bub, e_stall;

    always #5 clk = ~clk;

    hazard_stall_ctrl dut_a (
        .clk_i(clk), .rst_i(rst),
        .IFID_RS1_i(rs1), .IFID_RS2_i(rs2),
        .IDEX_MemRead_i(memread), .IDEX_RD_i(rd),
        .Branch_taken_i(bt), .mem_stall_i(stall),
        .PCWrite_o(a_pc), .IFID_Write_o(a_ifw), .IFID_Flush_o(a_flush),
        .IDEX_Bubble_o(a_bub), .Pipe_Stall_o(a_stall), .state_o(a_state),
        .miss_cyc_o(a_miss), .loaduse_cnt_o(a_lu), .flush_cnt_o(a_fl),
        .err_o(a_err)
    );

    hazard_stall_ctrl #(.CNT_W(4), .TIMEOUT(4)) dut_b (
        .clk_i(clk), .rst_i(rst),
        .IFID_RS1_i(rs1), .IFID_RS2_i(rs2),
        .IDEX_MemRead_i(memread), .IDEX_RD_i(rd),
        .Branch_taken_i(bt), .mem_stall_i(stall),
        .PCWrite_o(b_pc), .IFID_Write_o(b_ifw), .IFID_Flush_o(b_flush),
        .IDEX_Bubble_o(b_bub), .Pipe_Stall_o(b_stall), .state_o(b_state),
        .miss_cyc_o(b_miss), .loaduse_cnt_o(b_lu), .flush_cnt_o(b_fl),
        .err_o(b_err)
    );

    function automatic longint sat(longint v, int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    // Expected control outputs from the hazard rules.
    always_comb begin
        logic lu_hit, frozen;
        lu_hit  = memread && (rd != 0) && ((rd == rs1) || (rd == rs2));
        frozen  = stall || (m_st == 1);
        e_stall = !rst && frozen;
        e_bub   = !rst && !frozen && lu_hit;
        e_pc    = rst || (!frozen && !lu_hit);
        e_ifw   = e_pc;
        e_flush = !rst && !frozen && !lu_hit && (bt || m_pend);
    end

    task automatic model_reset();
        m_st = 0; m_pend = 0; m_miss = 0; m_lu = 0; m_fl = 0;
        m_run = 0; m_err_a = 0; m_err_b = 0;
    endtask

    // Advance the model across one clock edge.
    task automatic model_edge();
        bit fl, bub, frz;
        fl  = e_flush;
        bub = e_bub;
        frz = e_stall;
        m_run = (m_st == 1) ? m_run + 1 : 0;
        if (m_run >= 1024) m_err_a = 1;
        if (m_run >= 4)    m_err_b = 1;
        if (m_st == 1) m_miss++;
        if (bub) m_lu++;
        if (fl)  m_fl++;
        if (frz && bt) m_pend = 1;
        else if (fl)   m_pend = 0;
        m_st = stall ? 1 : ((m_st == 1) ? 2 : 0);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_in(bit s, bit b, bit mr, int d, int r1, int r2);
        stall = s; bt = b; memread = mr;
        rd = 5'(d); rs1 = 5'(r1); rs2 = 5'(r2);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        set_in(0, 0, 0, 0, 0, 0);
        do_reset();
        @(negedge clk);
        checks++;
        if ({a_state, a_pc, a_ifw, a_flush, a_bub, a_stall, a_err} !== 8'b00_11000_0) begin
            errors++;
            $display("FAIL reset_idle: got %b required %b", {a_state, a_pc, a_ifw, a_flush, a_bub, a_stall, a_err}, 8'b00110000);
        end
        // Enter a miss for five cycles, then reset asynchronously.
        set_in(1, 0, 0, 0, 0, 0);
        repeat (5) tick();
        checks++;
        if (a_state !== 2'd1 || a_miss === 32'd0) begin
            errors++;
            $display("FAIL reset_pre_miss: state %0d miss %0d required state 1 miss>0", a_state, a_miss);
        end
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if (a_state !== 2'd0 || a_miss !== 32'd0 || a_pc !== 1'b1 || a_stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: state %0d miss %0d pc %b stall %b required 0 0 1 0", a_state, a_miss, a_pc, a_stall);
        end
        @(posedge clk);
        #1;
        checks++;
        if (a_pc !== 1'b1 || a_ifw !== 1'b1 || b_state !== 2'd0) begin
            errors++;
            $display("FAIL reset_hold: pc %b ifw %b state %0d required 1 1 0", a_pc, a_ifw, b_state);
        end
        stall = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_load_use();
        do_reset();
        set_in(0, 0, 1, 5, 0, 5);
        @(negedge clk);
        checks++;
        if ({a_bub, a_pc, a_ifw, a_stall} !== 4'b1000) begin
            errors++;
            $display("FAIL load_use: bub/pc/ifw/stall %b required 1000", {a_bub, a_pc, a_ifw, a_stall});
        end
        tick();
        set_in(0, 0, 1, 0, 0, 0);
        @(negedge clk);
        checks++;
        if (a_lu !== 32'd1 || a_bub !== 1'b0 || a_pc !== 1'b1) begin
            errors++;
            $display("FAIL load_use_x0: cnt %0d bub %b pc %b required 1 0 1", a_lu, a_bub, a_pc);
        end
        tick();
        checks++;
        if (a_lu !== 32'd1) begin
            errors++;
            $display("FAIL load_use_cnt: got %0d required 1", a_lu);
        end
    endtask

    task automatic test_short_miss();
        logic [1:0] exp_st [4] = '{2'd0, 2'd1, 2'd2, 2'd0};
        logic       exp_sf [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_in(i == 0, 0, 0, 0, 0, 0);
            @(negedge clk);
            checks++;
            if (a_state !== exp_st[i] || a_stall !== exp_sf[i]) begin
                errors++;
                $display("FAIL short_miss[%0d]: state %0d stall %b required %0d %b", i, a_state, a_stall, exp_st[i], exp_sf[i]);
            end
            tick();
        end
        checks++;
        if (a_miss !== 32'd1) begin
            errors++;
            $display("FAIL short_miss_cnt: got %0d required 1", a_miss);
        end
    endtask

    task automatic test_deferred_flush();
        int n_flush = 0;
        int at = -1;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            set_in(i < 3, i < 3, 0, 0, 0, 0);
            @(negedge clk);
            if (a_flush === 1'b1) begin
                n_flush++;
                at = i;
            end
            tick();
        end
        checks++;
        if (n_flush != 1 || at != 4) begin
            errors++;
            $display("FAIL deferred_flush: count %0d cycle %0d required 1 at 4", n_flush, at);
        end
        checks++;
        if (a_fl !== 32'd1) begin
            errors++;
            $display("FAIL deferred_flush_cnt: got %0d required 1", a_fl);
        end
    endtask

    task automatic test_lu_branch();
        do_reset();
        set_in(0, 1, 1, 5, 5, 0);
        @(negedge clk);
        checks++;
        if (a_bub !== 1'b1 || a_flush !== 1'b0) begin
            errors++;
            $display("FAIL lu_branch: bub %b flush %b required 1 0", a_bub, a_flush);
        end
        tick();
        set_in(0, 1, 0, 5, 5, 0);
        @(negedge clk);
        checks++;
        if (a_bub !== 1'b0 || a_flush !== 1'b1) begin
            errors++;
            $display("FAIL lu_branch_next: bub %b flush %b required 0 1", a_bub, a_flush);
        end
        tick();
        set_in(0, 0, 0, 0, 0, 0);
        checks++;
        if (a_fl !== 32'd1 || a_lu !== 32'd1) begin
            errors++;
            $display("FAIL lu_branch_cnt: flush %0d lu %0d required 1 1", a_fl, a_lu);
        end
    endtask

    task automatic test_timeout_sat();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            set_in(1, 0, 0, 0, 0, 0);
            tick();
            checks++;
            if (b_err !== (i >= 4)) begin
                errors++;
                $display("FAIL timeout[%0d]: err %b required %b", i, b_err, (i >= 4));
            end
        end
        set_in(0, 0, 0, 0, 0, 0);
        repeat (3) tick();
        checks++;
        if (b_err !== 1'b1 || a_err !== 1'b0 || b_miss !== 4'd10) begin
            errors++;
            $display("FAIL timeout_sticky: err_b %b err_a %b miss_b %0d required 1 0 10", b_err, a_err, b_miss);
        end
        set_in(1, 0, 0, 0, 0, 0);
        repeat (8) tick();
        set_in(0, 0, 0, 0, 0, 0);
        repeat (3) tick();
        checks++;
        if (b_miss !== 4'hF || a_miss !== 32'd18) begin
            errors++;
            $display("FAIL miss_saturate: miss_b %0d miss_a %0d required 15 18", b_miss, a_miss);
        end
    endtask

    task automatic test_random();
        int burst = 0;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            if (burst == 0 && $urandom_range(0, 15) == 0) burst = $urandom_range(1, 8);
            stall   = (burst > 0) || ($urandom_range(0, 19) == 0);
            if (burst > 0) burst--;
            bt      = ($urandom_range(0, 9) < 3);
            memread = $urandom_range(0, 1);
            rd      = 5'($urandom_range(0, 3));
            rs1     = 5'($urandom_range(0, 3));
            rs2     = 5'($urandom_range(0, 3));
            @(negedge clk);
            checks++;
            if ({a_pc, a_ifw, a_flush, a_bub, a_stall} !== {e_pc, e_ifw, e_flush, e_bub, e_stall} ||
                {b_pc, b_ifw, b_flush, b_bub, b_stall} !== {e_pc, e_ifw, e_flush, e_bub, e_stall}) begin
                errors++;
                $display("FAIL rand_ctrl[%0d]: a %b b %b required %b", n,
                         {a_pc, a_ifw, a_flush, a_bub, a_stall}, {b_pc, b_ifw, b_flush, b_bub, b_stall},
                         {e_pc, e_ifw, e_flush, e_bub, e_stall});
            end
            checks++;
            if (a_state !== 2'(m_st) || b_state !== 2'(m_st)) begin
                errors++;
                $display("FAIL rand_state[%0d]: a %0d b %0d required %0d", n, a_state, b_state, m_st);
            end
            checks++;
            if (a_miss !== 32'(m_miss) || a_lu !== 32'(m_lu) || a_fl !== 32'(m_fl)) begin
                errors++;
                $display("FAIL rand_cnt_a[%0d]: %0d %0d %0d required %0d %0d %0d", n, a_miss, a_lu, a_fl, m_miss, m_lu, m_fl);
            end
            checks++;
            if (b_miss !== 4'(sat(m_miss, 4)) || b_lu !== 4'(sat(m_lu, 4)) || b_fl !== 4'(sat(m_fl, 4))) begin
                errors++;
                $display("FAIL rand_cnt_b[%0d]: %0d %0d %0d required %0d %0d %0d", n, b_miss, b_lu, b_fl,
                         sat(m_miss, 4), sat(m_lu, 4), sat(m_fl, 4));
            end
            checks++;
            if (a_err !== m_err_a || b_err !== m_err_b) begin
                errors++;
                $display("FAIL rand_err[%0d]: a %b b %b required %b %b", n, a_err, b_err, m_err_a, m_err_b);
            end
            tick();
        end
    endtask

    initial begin
        rst = 1'b1;
        set_in(0, 0, 0, 0, 0, 0);
        model_reset();
        #1;
        test_reset();
        test_load_use();
        test_short_miss();
        test_deferred_flush();
        test_lu_branch();
        test_timeout_sat();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Pipeline hazard controller for the 5-stage RISC-V core. It complements the forwarding unit: hazards that forwarding cannot resolve are handled here by holding the pipeline back instead of feeding data forward.
- Handles load-use bubbles, ID-stage branch flushes and full-pipeline freezes while the data cache services a miss.
- Registered FSM tracks miss/freeze episodes and defers flushes. Saturating performance counters and a sticky miss-timeout error support debug.

Parameters:
- CNT_W, 32, width of each performance counter.
- TIMEOUT, 1024, max consecutive MISS cycles before err_o sets; must be >= 2.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- IFID_RS1_i  in  5  rs1 of instruction in ID.
- IFID_RS2_i  in  5  rs2 of instruction in ID.
- IDEX_MemRead_i  in  1  instruction in EX is a load.
- IDEX_RD_i  in  5  rd of instruction in EX.
- Branch_taken_i  in  1  branch resolved taken in ID this cycle.
- mem_stall_i  in  1  dcache busy (miss in progress); level signal.
- PCWrite_o  out  1  PC update enable.
- IFID_Write_o  out  1  IF/ID register enable.
- IFID_Flush_o  out  1  zero the IF/ID register at next edge.
- IDEX_Bubble_o  out  1  force ID/EX control fields to zero.
- Pipe_Stall_o  out  1  freeze all pipeline registers and PC.
- state_o  out  2  FSM state: 0 RUN, 1 MISS, 2 RESUME.
- miss_cyc_o  out  CNT_W  cycles spent in MISS.
- loaduse_cnt_o  out  CNT_W  bubbles inserted.
- flush_cnt_o  out  CNT_W  flushes issued.
- err_o  out  1  sticky miss timeout.

Behaviour:
- Reset (async, any cycle, including mid-miss):
  - State RUN; counters 0; err_o 0; pending_flush 0; timeout counter 0.
  - Combinational outputs then take their RUN values: PCWrite_o=1, IFID_Write_o=1, others 0.
- Load-use condition, lu: IDEX_MemRead_i && IDEX_RD_i!=0 && (IDEX_RD_i==IFID_RS1_i || IDEX_RD_i==IFID_RS2_i).
- Freeze: frz = mem_stall_i || state==MISS.
  - Pipe_Stall_o=frz.
  - While frz: PCWrite_o=0, IFID_Write_o=0, IFID_Flush_o=0, IDEX_Bubble_o=0. The freeze has top priority.
- When not frozen:
  - If lu: PCWrite_o=0, IFID_Write_o=0, IDEX_Bubble_o=1.
  - Else: PCWrite_o=1, IFID_Write_o=1.
  - IFID_Flush_o = (Branch_taken_i || pending_flush) && !lu. Load-use holds ID, so the branch re-resolves next cycle.
- FSM transitions:
  - RUN -> MISS when mem_stall_i=1. Otherwise stay in RUN.
  - MISS: stays while mem_stall_i=1; -> RESUME when mem_stall_i=0.
    - The first MISS cycle keeps the freeze even if the cache drops stall early. Minimum freeze is 2 cycles.
  - RESUME: exactly 1 cycle; behaves as RUN for outputs.
    - -> MISS if mem_stall_i=1 (back-to-back miss); else -> RUN.
- Deferred flush:
  - If Branch_taken_i=1 in any frozen cycle, pending_flush sets at the edge.
  - pending_flush clears at the first edge where IFID_Flush_o=1.
- Timeout counter:
  - Counts consecutive MISS cycles; cleared on leaving MISS.
  - When it reaches TIMEOUT, err_o sets and remains 1 until reset. Counting saturates.
- Perf counters (all saturate at all-ones, no wrap):
  - miss_cyc_o +1 per cycle in state MISS.
  - loaduse_cnt_o +1 per cycle with IDEX_Bubble_o=1.
  - flush_cnt_o +1 per cycle with IFID_Flush_o=1.
- Simultaneous events:
  - lu and mem_stall_i: freeze only, no bubble, no count. lu is re-evaluated after the freeze.
  - lu and Branch_taken_i: bubble only, no flush.
  - rd=x0 with MemRead: never produces a bubble.

Test Plan:
- Reset mid-MISS (mem_stall_i=1 for 5 cycles, rst_i pulsed asynchronously) -> state_o=0 immediately, miss_cyc_o=0, PCWrite_o=1 while rst_i high.
- Load-use: IDEX_MemRead_i=1, IDEX_RD_i=5, IFID_RS2_i=5 for 1 cycle -> IDEX_Bubble_o=1, PCWrite_o=0, IFID_Write_o=0, loaduse_cnt_o=1. Repeat with IDEX_RD_i=0 -> no bubble.
- Miss of 1 cycle: mem_stall_i=1 for 1 cycle -> Pipe_Stall_o=1 for 2 cycles, state sequence RUN, MISS, RESUME, RUN, miss_cyc_o=1.
- Branch_taken_i=1 during a 3-cycle miss, then 0 -> IFID_Flush_o=1 exactly once, on the first unfrozen cycle; flush_cnt_o=1; pending_flush cleared.
- Load-use with Branch_taken_i=1 simultaneously -> bubble only, IFID_Flush_o=0. Next cycle lu=0, branch still taken -> IFID_Flush_o=1.
- TIMEOUT=4, mem_stall_i held 10 cycles -> err_o rises after the 4th MISS cycle and stays 1 after mem_stall_i drops. Force the miss counter near all-ones, run 3 more MISS cycles -> miss_cyc_o saturates at all-ones.
